lock_seq_ctrl: RTL and testbench

- Sequencing controller for the electronic lock datapath: code entry, check, unlock, lockout pause and entry timeout.
- Owns the attempt counter, all timers and the display glyph word.
- Display strobing stays downstream; the 7-segment mux consumes `disp_glyphs` as four 5-bit glyph indices.
- Timers advance only on `tick`, a 1 kHz single-cycle strobe from the shared clock-enable generator.

---
 rtl/lock_pkg.sv | 37 +++
 rtl/tick_timer.sv | 32 +++
 rtl/lock_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lock_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock sequencing controller.
//   - Glyph indices understood by the downstream 7-segment mux.
//   - Fixed 20-bit display words {g3,g2,g1,g0}.
//   - Controller state encoding.
//   - Helper that checks a displayed glyph word against the unlock code.
package lock_pkg;

  localparam logic [4:0] GLY_BLANK = 5'd16;
  localparam logic [4:0] GLY_U     = 5'd21;
  localparam logic [4:0] GLY_N     = 5'd22;
  localparam logic [4:0] GLY_L     = 5'd23;
  localparam logic [4:0] GLY_O     = 5'd24;
  localparam logic [4:0] GLY_C     = 5'd25;
  localparam logic [4:0] GLY_P     = 5'd26;
  localparam logic [4:0] GLY_A     = 5'd27;
  localparam logic [4:0] GLY_PU    = 5'd28;
  localparam logic [4:0] GLY_S     = 5'd29;

  localparam logic [19:0] WORD_LOC  = {GLY_BLANK, GLY_L, GLY_O, GLY_C};
  localparam logic [19:0] WORD_UNLC = {GLY_U, GLY_N, GLY_L, GLY_C};
  localparam logic [19:0] WORD_PAUS = {GLY_P, GLY_A, GLY_PU, GLY_S};

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_PAUSE    = 2'd3
  } state_e;

  // A glyph >= 16 is not a digit, so any such glyph makes the entry wrong.
  function automatic logic code_match(input logic [19:0] g, input logic [15:0] code);
    logic all_digits;
    all_digits = ~(g[19] | g[14] | g[9] | g[4]);
    return all_digits && ({g[18:15], g[13:10], g[8:5], g[3:0]} == code);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// 16-bit loadable down-counter advanced by a tick enable.
//   clk, rst    : clock, synchronous active-high reset (count cleared)
//   load_i      : load load_val_i (wins over counting)
//   load_val_i  : reload value
//   run_i       : counting allowed
//   tick_i      : single-cycle advance strobe
//   done_o      : combinational pulse on the tick that takes the count to 0
module tick_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        run_i,
  input  logic        tick_i,
  output logic        done_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (run_i && tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign done_o = run_i && tick_i && (cnt_q == 16'd1);

endmodule

// File: rtl/lock_seq_ctrl.sv
// Sequencing controller for the electronic lock: code entry, check, unlock,
// lockout pause and entry timeout. Owns attempts, timers and glyph word.
//   clk, rst     : clock, synchronous active-high reset
//   tick         : 1 kHz single-cycle timer strobe
//   btn[3:0]     : one-hot digit load, btn[3]=digit0 ... btn[0]=digit3
//   switch[3:0]  : digit value
//   latch, lock  : check / relock requests, acted on at their falling edge
//   disp_glyphs  : {g3,g2,g1,g0} glyph indices (registered)
//   led[7:0]     : status LEDs (registered)
//   state_o[2:0] : current state, debug
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter logic [15:0] UNLOCK_CODE   = 16'h3283,
  parameter int unsigned TIMEOUT_TICKS = 30000,
  parameter int unsigned PAUSE_TICKS   = 20000,
  parameter int unsigned BLINK_TICKS   = 500,
  parameter int unsigned MAX_ATTEMPTS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  btn,
  input  logic [3:0]  switch,
  input  logic        latch,
  input  logic        lock,
  output logic [19:0] disp_glyphs,
  output logic [7:0]  led,
  output logic [2:0]  state_o
);

  if (TIMEOUT_TICKS > 32'h0000_FFFF || PAUSE_TICKS > 32'h0000_FFFF ||
      BLINK_TICKS > 32'h0000_FFFF) begin : g_tick_range
    $error("lock_seq_ctrl: *_TICKS parameters must be below 2**16");
  end
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 255) begin : g_att_range
    $error("lock_seq_ctrl: MAX_ATTEMPTS must be in 1..255");
  end

  localparam logic [7:0] MAX_ATT = 8'(MAX_ATTEMPTS);

  state_e      state_q, state_d;
  logic [19:0] glyphs_q, glyphs_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  attempts_q, attempts_d, att_inc;
  logic        latch_prev_q, lock_prev_q;
  logic        latch_fall, lock_fall, btn_ok;
  logic        to_load, pause_load, blink_load;
  logic        to_done, pause_done, blink_done;

  assign latch_fall = latch_prev_q & ~latch;
  assign lock_fall  = lock_prev_q & ~lock;
  assign btn_ok     = $onehot(btn);

  tick_timer u_timeout (
    .clk(clk), .rst(rst), .load_i(to_load), .load_val_i(16'(TIMEOUT_TICKS)),
    .run_i(state_q == ST_ENTRY), .tick_i(tick), .done_o(to_done)
  );

  tick_timer u_pause (
    .clk(clk), .rst(rst), .load_i(pause_load), .load_val_i(16'(PAUSE_TICKS)),
    .run_i(state_q == ST_PAUSE), .tick_i(tick), .done_o(pause_done)
  );

  tick_timer u_blink (
    .clk(clk), .rst(rst), .load_i(blink_load), .load_val_i(16'(BLINK_TICKS)),
    .run_i(state_q == ST_UNLOCKED), .tick_i(tick), .done_o(blink_done)
  );

  always_comb begin
    state_d    = state_q;
    glyphs_d   = glyphs_q;
    led_d      = led_q;
    attempts_d = attempts_q;
    att_inc    = attempts_q + 8'd1;
    to_load    = 1'b0;
    pause_load = 1'b0;
    blink_load = 1'b0;
    unique case (state_q)
      ST_LOCKED, ST_ENTRY: begin
        led_d = {2'b00, lock, latch, switch};
        // Priority: latch fall > lock fall > timeout > digit press.
        if (latch_fall) begin
          if (code_match(glyphs_q, UNLOCK_CODE)) begin
            state_d    = ST_UNLOCKED;
            glyphs_d   = WORD_UNLC;
            attempts_d = '0;
            blink_load = 1'b1;
            led_d      = 8'hFF;
          end else if (att_inc < MAX_ATT) begin
            state_d    = ST_LOCKED;
            glyphs_d   = WORD_LOC;
            attempts_d = att_inc;
          end else begin
            state_d    = ST_PAUSE;
            glyphs_d   = WORD_PAUS;
            attempts_d = '0;
            pause_load = 1'b1;
            led_d      = '0;
          end
        end else if (lock_fall) begin
          state_d    = ST_LOCKED;
          glyphs_d   = WORD_LOC;
          attempts_d = '0;
        end else if (state_q == ST_ENTRY && to_done) begin
          state_d  = ST_LOCKED;
          glyphs_d = WORD_LOC;
        end else if (btn_ok) begin
          case (btn)
            4'b0001: glyphs_d[19:15] = {1'b0, switch};
            4'b0010: glyphs_d[14:10] = {1'b0, switch};
            4'b0100: glyphs_d[9:5]   = {1'b0, switch};
            4'b1000: glyphs_d[4:0]   = {1'b0, switch};
            default: ;
          endcase
          // Timeout runs from the first digit only; later digits do not restart it.
          if (state_q == ST_LOCKED) begin
            state_d = ST_ENTRY;
            to_load = 1'b1;
          end
        end
      end
      ST_UNLOCKED: begin
        if (lock_fall) begin
          state_d  = ST_LOCKED;
          glyphs_d = WORD_LOC;
          led_d    = {2'b00, lock, latch, switch};
        end else if (blink_done) begin
          led_d      = ~led_q;
          blink_load = 1'b1;
        end
      end
      ST_PAUSE: begin
        led_d = '0;
        if (pause_done) begin
          state_d  = ST_LOCKED;
          glyphs_d = WORD_LOC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // Edge history always tracks the inputs, so reset never leaves a stale edge.
    latch_prev_q <= latch;
    lock_prev_q  <= lock;
    if (rst) begin
      state_q    <= ST_LOCKED;
      glyphs_q   <= WORD_LOC;
      led_q      <= '0;
      attempts_q <= '0;
    end else begin
      state_q    <= state_d;
      glyphs_q   <= glyphs_d;
      led_q      <= led_d;
      attempts_q <= attempts_d;
    end
  end

  assign disp_glyphs = glyphs_q;
  assign led         = led_q;
  assign state_o     = {1'b0, state_q};

endmodule

// File: tb/tb_lock_seq_ctrl.sv
module tb_lock_seq_ctrl;

  localparam int unsigned TO = 300;
  localparam int unsigned PA = 200;
  localparam int unsigned BL = 50;

  localparam logic [19:0] W_LOC  = {5'd16, 5'd23, 5'd24, 5'd25};
  localparam logic [19:0] W_UNLC = {5'd21, 5'd22, 5'd23, 5'd25};
  localparam logic [19:0] W_PAUS = {5'd26, 5'd27, 5'd28, 5'd29};

  logic        clk = 1'b0;
  logic        rst, tick, latch, lock;
  logic [3:0]  btn, switch;
  logic [19:0] disp_glyphs;
  logic [7:0]  led;
  logic [2:0]  state_o;

  lock_seq_ctrl #(
    .UNLOCK_CODE(16'h3283), .TIMEOUT_TICKS(TO), .PAUSE_TICKS(PA),
    .BLINK_TICKS(BL), .MAX_ATTEMPTS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn), .switch(switch),
    .latch(latch), .lock(lock), .disp_glyphs(disp_glyphs), .led(led),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  string       q_name[$];
  logic [19:0] q_gly[$];
  logic [2:0]  q_st[$];
  bit          q_chkl[$];
  logic [7:0]  q_led[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [19:0] gw(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  task automatic expect_o(input string nm, input logic [19:0] g, input logic [2:0] s,
                          input bit chkl, input logic [7:0] l);
    q_name.push_back(nm);
    q_gly.push_back(g);
    q_st.push_back(s);
    q_chkl.push_back(chkl);
    q_led.push_back(l);
  endtask

  task automatic check_now(input string nm, input logic [19:0] g, input logic [2:0] s,
                           input bit chkl, input logic [7:0] l);
    n_tests++;
    if (disp_glyphs !== g || state_o !== s || (chkl && led !== l)) begin
      n_fail++;
      $display("FAIL(now) %s: got glyphs=%h state=%0d led=%h, want glyphs=%h state=%0d led=%h",
               nm, disp_glyphs, state_o, led, g, s, l);
    end
  endtask

  always @(negedge clk) begin
    while (q_name.size() != 0) begin
      string       nm;
      logic [19:0] eg;
      logic [2:0]  es;
      bit          ec;
      logic [7:0]  el;
      nm = q_name.pop_front();
      eg = q_gly.pop_front();
      es = q_st.pop_front();
      ec = q_chkl.pop_front();
      el = q_led.pop_front();
      n_tests++;
      if (disp_glyphs !== eg || state_o !== es || (ec && led !== el)) begin
        n_fail++;
        $display("FAIL %s: got glyphs=%h state=%0d led=%h, want glyphs=%h state=%0d led=%h (led checked=%0d)",
                 nm, disp_glyphs, state_o, led, eg, es, el, ec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b, input logic [3:0] v);
    btn = b; switch = v; step(); btn = '0;
  endtask

  task automatic latch_pulse();
    latch = 1'b1; step(); latch = 1'b0; step();
  endtask

  task automatic lock_pulse();
    lock = 1'b1; step(); lock = 1'b0; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(4'b0001, c[15:12]); press(4'b0010, c[11:8]);
    press(4'b0100, c[7:4]);   press(4'b1000, c[3:0]);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; btn = '0; switch = '0; latch = 1'b0; lock = 1'b0;
    step(); step();
    check_now("reset_now", W_LOC, 3'd0, 1'b1, 8'h00);
    expect_o("reset", W_LOC, 3'd0, 1'b1, 8'h00);
    rst = 1'b0; switch = 4'hA; step();
    expect_o("locked_led", W_LOC, 3'd0, 1'b1, 8'h0A);
    btn = 4'b0011; step(); btn = '0;
    expect_o("btn_not_onehot", W_LOC, 3'd0, 1'b1, 8'h0A);

    press(4'b0001, 4'd3);
    expect_o("first_digit", gw(3, 23, 24, 25), 3'd1, 1'b1, 8'h03);
    press(4'b0010, 4'd2); press(4'b0100, 4'd8); press(4'b1000, 4'd3);
    expect_o("code_entered", gw(3, 2, 8, 3), 3'd1, 1'b1, 8'h03);
    latch_pulse();
    expect_o("unlock", W_UNLC, 3'd2, 1'b1, 8'hFF);
    ticks(BL - 1);
    expect_o("blink_hold", W_UNLC, 3'd2, 1'b1, 8'hFF);
    tick = 1'b1; step(); tick = 1'b0;
    expect_o("blink_off", W_UNLC, 3'd2, 1'b1, 8'h00);
    ticks(BL);
    expect_o("blink_on", W_UNLC, 3'd2, 1'b1, 8'hFF);
    press(4'b0001, 4'd9);
    expect_o("unlocked_btn_ignored", W_UNLC, 3'd2, 1'b1, 8'hFF);
    latch_pulse();
    expect_o("unlocked_latch_ignored", W_UNLC, 3'd2, 1'b1, 8'hFF);
    lock_pulse();
    expect_o("relock", W_LOC, 3'd0, 1'b0, 8'h00);
    step();
    expect_o("relock_led", W_LOC, 3'd0, 1'b1, 8'h09);

    enter_code(16'h1234);
    expect_o("wrong_entered", gw(1, 2, 3, 4), 3'd1, 1'b1, 8'h04);
    latch_pulse();
    expect_o("miss1", W_LOC, 3'd0, 1'b0, 8'h00);
    enter_code(16'h0000);
    latch_pulse();
    expect_o("miss2_pause", W_PAUS, 3'd3, 1'b1, 8'h00);
    press(4'b0001, 4'd5);
    expect_o("pause_btn", W_PAUS, 3'd3, 1'b1, 8'h00);
    lock_pulse();
    expect_o("pause_lock", W_PAUS, 3'd3, 1'b1, 8'h00);
    latch_pulse();
    expect_o("pause_latch", W_PAUS, 3'd3, 1'b1, 8'h00);
    ticks(PA - 1);
    expect_o("pause_hold", W_PAUS, 3'd3, 1'b1, 8'h00);
    tick = 1'b1; step(); tick = 1'b0;
    check_now("pause_expire_now", W_LOC, 3'd0, 1'b1, 8'h00);
    expect_o("pause_expire", W_LOC, 3'd0, 1'b0, 8'h00);

    press(4'b1000, 4'd7);
    expect_o("digit0_only", gw(16, 23, 24, 7), 3'd1, 1'b0, 8'h00);
    ticks(TO - 1);
    expect_o("timeout_hold", gw(16, 23, 24, 7), 3'd1, 1'b0, 8'h00);
    tick = 1'b1; step(); tick = 1'b0;
    check_now("timeout_now", W_LOC, 3'd0, 1'b0, 8'h00);
    expect_o("timeout", W_LOC, 3'd0, 1'b0, 8'h00);
    enter_code(16'h3283);
    ticks(TO - 1);
    expect_o("timeout_hold2", gw(3, 2, 8, 3), 3'd1, 1'b0, 8'h00);
    latch = 1'b1; step();
    latch = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    expect_o("latch_beats_timeout", W_UNLC, 3'd2, 1'b1, 8'hFF);
    lock_pulse();
    expect_o("relock2", W_LOC, 3'd0, 1'b0, 8'h00);

    press(4'b0001, 4'd0);
    latch_pulse();
    expect_o("t5_miss", W_LOC, 3'd0, 1'b0, 8'h00);
    lock_pulse();
    expect_o("t5_lock_clear", W_LOC, 3'd0, 1'b0, 8'h00);
    latch_pulse();
    expect_o("t5_miss_after_clear", W_LOC, 3'd0, 1'b0, 8'h00);
    latch_pulse();
    expect_o("t5_locked_miss_pause", W_PAUS, 3'd3, 1'b1, 8'h00);
    ticks(PA);
    expect_o("t5_pause_done", W_LOC, 3'd0, 1'b0, 8'h00);

    press(4'b0010, 4'd5);
    expect_o("t6_entry", gw(16, 5, 24, 25), 3'd1, 1'b0, 8'h00);
    rst = 1'b1; step();
    check_now("rst_entry_now", W_LOC, 3'd0, 1'b1, 8'h00);
    expect_o("rst_entry", W_LOC, 3'd0, 1'b1, 8'h00);
    rst = 1'b0; step();
    enter_code(16'h3283);
    latch_pulse();
    expect_o("t6_unlock", W_UNLC, 3'd2, 1'b1, 8'hFF);
    lock = 1'b1; step();
    rst = 1'b1; step();
    expect_o("rst_unlocked", W_LOC, 3'd0, 1'b1, 8'h00);
    lock = 1'b0; step();
    expect_o("rst_lock_release", W_LOC, 3'd0, 1'b1, 8'h00);
    rst = 1'b0; step();
    expect_o("after_rst", W_LOC, 3'd0, 1'b1, 8'h03);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
